// File: rtl/pulse_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pulse_tx : pulse-width symbol transmitter ('1' long high, '0' short high, |
// |            each followed by a low gap). Optional abort: PULSE_TX_ABORT_EN |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module pulse_tx #(
   parameter int NBITS     = 4,
   parameter int LONG_LEN  = 10,
   parameter int SHORT_LEN = 3,
   parameter int GAP_LEN   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [NBITS-1:0] data,
`ifdef PULSE_TX_ABORT_EN
   input  logic             abort,
`endif
   output logic             A,
   output logic             busy,
   output logic             done
);

   localparam int SW = (NBITS > 1) ? $clog2(NBITS) : 1;

   localparam logic [7:0]    c_long_m1  = 8'(LONG_LEN - 1);
   localparam logic [7:0]    c_short_m1 = 8'(SHORT_LEN - 1);
   localparam logic [7:0]    c_gap_m1   = 8'(GAP_LEN - 1);
   localparam logic [SW-1:0] c_left_init = SW'(NBITS - 1);
   localparam logic [SW-1:0] c_left_one  = SW'(1);

   generate
      if (NBITS < 1 || NBITS > 255 ||
          LONG_LEN < 9 || LONG_LEN > 255 ||
          SHORT_LEN < 1 || SHORT_LEN >= LONG_LEN ||
          GAP_LEN < 1 || GAP_LEN > 255) begin : g_param_check
         $error("pulse_tx: illegal parameter set");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [7:0]       r_cnt, w_cnt_nxt;
   logic [NBITS-1:0] r_shift, w_shift_nxt, w_shifted;
   logic [SW-1:0]    r_left, w_left_nxt;
   logic             r_a, w_a_nxt;
   logic             r_busy, w_busy_nxt;
   logic             r_done, w_done_nxt;
   logic             w_abort;

`ifdef PULSE_TX_ABORT_EN
   assign w_abort = abort;
`else
   assign w_abort = 1'b0;
`endif

   function automatic logic [7:0] sym_len_m1(input logic sym);
      return sym ? c_long_m1 : c_short_m1;
   endfunction

   assign w_shifted = r_shift << 1;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_shift_nxt = r_shift;
      w_left_nxt  = r_left;
      w_done_nxt  = 1'b0;

      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt = HIGH;
               w_shift_nxt = data;
               w_left_nxt  = c_left_init;
               w_cnt_nxt   = sym_len_m1(data[NBITS-1]);
            end
         end
         HIGH: begin
            if (r_cnt == 8'd0) begin
               w_state_nxt = GAP;
               w_cnt_nxt   = c_gap_m1;
            end else begin
               w_cnt_nxt = r_cnt - 8'd1;
            end
         end
         GAP: begin
            if (r_cnt == 8'd0) begin
               if (r_left == '0) begin
                  w_state_nxt = IDLE;
                  w_done_nxt  = 1'b1;
               end else begin
                  // Next symbol is the MSB after the shift.
                  w_state_nxt = HIGH;
                  w_shift_nxt = w_shifted;
                  w_left_nxt  = r_left - c_left_one;
                  w_cnt_nxt   = sym_len_m1(w_shifted[NBITS-1]);
               end
            end else begin
               w_cnt_nxt = r_cnt - 8'd1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 8'd0;
         end
      endcase

      // Abort wins over everything, including a start in IDLE.
      if (w_abort) begin
         w_state_nxt = IDLE;
         w_cnt_nxt   = 8'd0;
         w_done_nxt  = 1'b0;
      end

      w_a_nxt    = (w_state_nxt == HIGH);
      w_busy_nxt = (w_state_nxt != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= 8'd0;
         r_shift <= '0;
         r_left  <= '0;
         r_a     <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_shift <= w_shift_nxt;
         r_left  <= w_left_nxt;
         r_a     <= w_a_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign A    = r_a;
   assign busy = r_busy;
   assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pulse_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pulse_tx : directed self-checking bench for pulse_tx (default params) |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_pulse_tx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [3:0] data;
`ifdef PULSE_TX_ABORT_EN
   logic       abort;
`endif
   logic       A;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   logic a_log [0:255];
   int   a_len;
   int   busy_bad;
   logic got_done;
   int   runs [8];
   int   det_run = 0;
   int   det_cnt = 0;
   int   det_base;
   int   done_seen;

   pulse_tx dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .data  (data),
`ifdef PULSE_TX_ABORT_EN
      .abort (abort),
`endif
      .A     (A),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   // Long-press detector fed back from A: fires once on the 9th high cycle of a run.
   always @(posedge clk) begin
      if (A) det_run <= det_run + 1;
      else   det_run <= 0;
      if (A && det_run == 8) det_cnt <= det_cnt + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge observing the first frame cycle.
   task automatic launch(input logic [3:0] d);
      start = 1'b1;
      data  = d;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Logs A from the current negedge until done is seen (bounded).
   task automatic capture(input int chg_at, input logic [3:0] chg_d);
      a_len    = 0;
      busy_bad = 0;
      got_done = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (done) begin
            got_done = 1'b1;
            break;
         end
         if (!busy) busy_bad++;
         a_log[a_len] = A;
         a_len++;
         if (i == chg_at) data = chg_d;
         @(negedge clk);
      end
   endtask

   function automatic int pattern_err();
      int   idx = 0;
      int   err = 0;
      logic lvl = 1'b1;
      for (int r = 0; r < 8; r++) begin
         for (int k = 0; k < runs[r]; k++) begin
            if (idx >= a_len || a_log[idx] !== lvl) err++;
            idx++;
         end
         lvl = ~lvl;
      end
      if (idx != a_len) err++;
      return err;
   endfunction

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      data  = 4'b0000;
`ifdef PULSE_TX_ABORT_EN
      abort = 1'b0;
`endif
      repeat (2) @(negedge clk);
      start = 1'b1;
      data  = 4'b1111;
      @(negedge clk);
      chk_bit("rst_A", A, 1'b0);
      chk_bit("rst_busy", busy, 1'b0);
      chk_bit("rst_done", done, 1'b0);
      start = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk_bit("idle_busy", busy, 1'b0);
      chk_bit("idle_A", A, 1'b0);

      // data 1010: 10/2/3/2/10/2/3/2, 34 cycles to done
      det_base = det_cnt;
      launch(4'b1010);
      capture(-1, 4'b0000);
      runs = '{10, 2, 3, 2, 10, 2, 3, 2};
      chk_bit("t1_done_seen", got_done, 1'b1);
      chk_int("t1_len", a_len, 34);
      chk_int("t1_pattern", pattern_err(), 0);
      chk_int("t1_busy_in_frame", busy_bad, 0);
      chk_bit("t1_busy_at_done", busy, 1'b0);
      chk_bit("t1_A_at_done", A, 1'b0);
      chk_int("t1_detector", det_cnt - det_base, 2);
      @(negedge clk);
      chk_bit("t1_done_once", done, 1'b0);
      chk_bit("t1_idle_A", A, 1'b0);

      // data 0000: four 3-high / 2-low symbols
      det_base = det_cnt;
      launch(4'b0000);
      capture(-1, 4'b0000);
      runs = '{3, 2, 3, 2, 3, 2, 3, 2};
      chk_bit("t2_done_seen", got_done, 1'b1);
      chk_int("t2_len", a_len, 20);
      chk_int("t2_pattern", pattern_err(), 0);
      chk_int("t2_detector", det_cnt - det_base, 0);
      @(negedge clk);
      chk_bit("t2_done_once", done, 1'b0);

      // start held, data changed mid-frame, back-to-back second frame
      start = 1'b1;
      data  = 4'b1100;
      @(negedge clk);
      capture(5, 4'b0011);
      runs = '{10, 2, 10, 2, 3, 2, 3, 2};
      chk_bit("t3_done_seen", got_done, 1'b1);
      chk_int("t3_len", a_len, 34);
      chk_int("t3_pattern", pattern_err(), 0);
      chk_bit("t3_busy_at_done", busy, 1'b0);
      @(negedge clk);
      start = 1'b0;
      chk_bit("t3_b2b_A", A, 1'b1);
      chk_bit("t3_b2b_busy", busy, 1'b1);
      chk_bit("t3_b2b_done", done, 1'b0);
      capture(-1, 4'b0000);
      runs = '{3, 2, 3, 2, 10, 2, 10, 2};
      chk_bit("t3b_done_seen", got_done, 1'b1);
      chk_int("t3b_len", a_len, 34);
      chk_int("t3b_pattern", pattern_err(), 0);
      @(negedge clk);

      // loopback detector on 1011
      det_base = det_cnt;
      launch(4'b1011);
      capture(-1, 4'b0000);
      chk_bit("t5_done_seen", got_done, 1'b1);
      chk_int("t5_len", a_len, 41);
      chk_int("t5_detector", det_cnt - det_base, 3);
      @(negedge clk);

      // reset during the second HIGH
      launch(4'b1111);
      repeat (13) @(negedge clk);
      chk_bit("t4_in_high2", A, 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      chk_bit("t4_rst_A", A, 1'b0);
      chk_bit("t4_rst_busy", busy, 1'b0);
      chk_bit("t4_rst_done", done, 1'b0);
      rst_n = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (done || A) done_seen++;
      end
      chk_int("t4_no_done", done_seen, 0);

`ifdef PULSE_TX_ABORT_EN
      // abort in GAP after symbol 0
      launch(4'b1010);
      repeat (10) @(negedge clk);
      chk_bit("t6_in_gap_A", A, 1'b0);
      chk_bit("t6_in_gap_busy", busy, 1'b1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk_bit("t6_abort_busy", busy, 1'b0);
      chk_bit("t6_abort_A", A, 1'b0);
      chk_bit("t6_abort_done", done, 1'b0);
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done || busy) done_seen++;
      end
      chk_int("t6_no_done", done_seen, 0);
      // abort beats a simultaneous start
      abort = 1'b1;
      start = 1'b1;
      data  = 4'b1111;
      @(negedge clk);
      abort = 1'b0;
      start = 1'b0;
      chk_bit("t6_abort_start_busy", busy, 1'b0);
      chk_bit("t6_abort_start_A", A, 1'b0);
      @(negedge clk);
      launch(4'b0101);
      capture(-1, 4'b0000);
      runs = '{3, 2, 10, 2, 3, 2, 10, 2};
      chk_bit("t6_done_seen", got_done, 1'b1);
      chk_int("t6_len", a_len, 34);
      chk_int("t6_pattern", pattern_err(), 0);
      @(negedge clk);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
